// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the push/pop queue scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } state_e;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    // One slot of the 8-entry queue is left unused so count fits in 3 bits.
    localparam logic [2:0] CAPACITY = 3'd7;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with registered read data (DEPTH must be a power of two).
// Latency: write visible the cycle after wr_en; rd_data updates the cycle after rd_en.
// Backpressure: writes ignored when full, reads ignored when empty.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      used_q, used_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             do_wr, do_rd;

    always_comb begin
        do_wr     = wr_en && !full;
        do_rd     = rd_en && !empty;
        wr_ptr_d  = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rd_data_d = do_rd ? mem[rd_ptr_q] : rd_data_q;
        used_d    = used_q;
        if (do_wr && !do_rd) begin
            used_d = used_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            used_d = used_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            used_q    <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            used_q    <= used_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign full    = (used_q == (AW+1)'(DEPTH));
    assign empty   = (used_q == '0);
    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sched_rr_arb2.sv
// Two-way round-robin pick: lone requester wins, ptr breaks ties.
// Latency: combinational.
// Backpressure: none; caller decides whether the pick is used.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = ptr ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/fifo_sched.sv
// Schedules one push (two producers, round-robin) or one pop per cycle onto an external queue.
// Latency: enqueue/dequeue/gnt one cycle after request; rd_valid one cycle after dequeue.
// Backpressure: pushes held off at count==7, pops held off at count==0.
module fifo_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             enqueue,
    output logic             dequeue,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic [2:0]       count
);
    import fifo_sched_pkg::*;

    state_e           state_q, state_d;
    op_e              last_op_q, last_op_d;
    logic [2:0]       count_q, count_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] data_in_q, data_in_d;
    logic             rd_valid_q, rd_valid_d;
    logic [1:0]       win;
    logic             push_ok, pop_ok;

    rr_arb2 u_arb (
        .req ({req1, req0}),
        .ptr (rr_ptr_q),
        .win (win)
    );

    always_comb begin
        push_ok    = (count_q < CAPACITY) && (req0 || req1);
        pop_ok     = (count_q != 3'd0) && pop;
        state_d    = IDLE;
        // When both are possible, alternate so neither side starves.
        if (push_ok && pop_ok) begin
            state_d = (last_op_q == OP_PUSH) ? POP : PUSH;
        end else if (push_ok) begin
            state_d = PUSH;
        end else if (pop_ok) begin
            state_d = POP;
        end

        last_op_d  = last_op_q;
        count_d    = count_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = 2'b00;
        data_in_d  = '0;
        rd_valid_d = (state_q == POP);

        case (state_d)
            PUSH: begin
                last_op_d = OP_PUSH;
                count_d   = count_q + 3'd1;
                gnt_d     = win;
                data_in_d = win[1] ? data1 : data0;
                rr_ptr_d  = win[0];
            end
            POP: begin
                last_op_d = OP_POP;
                count_d   = count_q - 3'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_op_q  <= OP_POP;
            count_q    <= 3'd0;
            rr_ptr_q   <= 1'b0;
            gnt_q      <= 2'b00;
            data_in_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_op_q  <= last_op_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            data_in_q  <= data_in_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign enqueue  = (state_q == PUSH);
    assign dequeue  = (state_q == POP);
    assign gnt0     = gnt_q[0];
    assign gnt1     = gnt_q[1];
    assign data_in  = data_in_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = fifo_data_out;
    assign count    = count_q;

endmodule
